// File: rtl/refresh_rate.sv
// Frame-refresh strobe generator: divides `clock` down to REFRESH_RATE Hz using
// an integer period plus a remainder accumulator, so the long-run rate is exact.
module refresh_rate #(
  parameter int CLOCK_FREQ   = 50000000,
  parameter int REFRESH_RATE = 60,
  parameter int PULSE_CYCLES = 1
) (
  input  logic clock,
  input  logic reset,
  output logic refreshRate
);

  // Guarded copies keep the arithmetic and widths well-defined even when the
  // legality checks below fire, so the only report is the intended one.
  localparam int RR_SAFE = (REFRESH_RATE >= 1) ? REFRESH_RATE : 1;
  localparam int Q       = CLOCK_FREQ / RR_SAFE;
  localparam int R       = CLOCK_FREQ % RR_SAFE;
  localparam int Q_SAFE  = (Q >= 2) ? Q : 2;
  localparam int P_SAFE  = (PULSE_CYCLES >= 1) ? PULSE_CYCLES : 1;

  localparam int CW = $clog2(Q_SAFE + 1);
  localparam int AW = $clog2(RR_SAFE + 1);
  localparam int PW = $clog2(P_SAFE + 1);

  generate
    if (REFRESH_RATE < 1) begin : g_bad_rate
      $error("refresh_rate: REFRESH_RATE (%0d) must be >= 1", REFRESH_RATE);
    end
    if (Q < 2) begin : g_bad_period
      $error("refresh_rate: CLOCK_FREQ/REFRESH_RATE (%0d) must be >= 2", Q);
    end
    if (PULSE_CYCLES < 1 || PULSE_CYCLES > Q - 1) begin : g_bad_pulse
      $error("refresh_rate: PULSE_CYCLES (%0d) must be in 1..%0d", PULSE_CYCLES, Q - 1);
    end
  endgenerate

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic          strobe_q, strobe_d;

  logic [AW:0]   acc_sum;
  logic          carry;
  logic [CW-1:0] last_cnt;
  logic          period_end;

  // The current period is one cycle longer whenever adding R to the running
  // remainder wraps past REFRESH_RATE; this puts period k's end at
  // floor(k * CLOCK_FREQ / REFRESH_RATE).
  always_comb begin
    acc_sum    = {1'b0, acc_q} + (AW+1)'(R);
    carry      = (acc_sum >= (AW+1)'(RR_SAFE));
    last_cnt   = CW'(Q_SAFE - 1) + CW'(carry);
    period_end = (count_q == last_cnt);
  end

  // NOTE: every next-state signal gets a default first, so no path through
  // this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    count_d     = count_q;
    acc_d       = acc_q;
    pulse_cnt_d = pulse_cnt_q;
    strobe_d    = strobe_q;

    if (period_end) begin
      count_d     = '0;
      acc_d       = carry ? AW'(acc_sum - (AW+1)'(RR_SAFE)) : AW'(acc_sum);
      strobe_d    = 1'b1;
      pulse_cnt_d = PW'(P_SAFE - 1);
    end else begin
      count_d = count_q + CW'(1);
      if (pulse_cnt_q != '0) begin
        pulse_cnt_d = pulse_cnt_q - PW'(1);
      end else begin
        strobe_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, matching real hardware.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q     <= '0;
      acc_q       <= '0;
      pulse_cnt_q <= '0;
      strobe_q    <= 1'b0;
    end else begin
      count_q     <= count_d;
      acc_q       <= acc_d;
      pulse_cnt_q <= pulse_cnt_d;
      strobe_q    <= strobe_d;
    end
  end

  assign refreshRate = strobe_q;

endmodule

// File: tb/tb_refresh_rate.sv
// Self-checking bench for refresh_rate: four differently parameterised
// instances checked every cycle against an arithmetic model of pulse edges.
module tb_refresh_rate;

  localparam int CF0 = 100;   localparam int RR0 = 7;  localparam int P0 = 1;
  localparam int CF1 = 100;   localparam int RR1 = 10; localparam int P1 = 3;
  localparam int CF2 = 997;   localparam int RR2 = 13; localparam int P2 = 5;
  localparam int CF3 = 50000; localparam int RR3 = 60; localparam int P3 = 1;

  logic clock = 1'b0;
  logic rst [4];
  logic out [4];

  always #5 clock = ~clock;

  refresh_rate #(.CLOCK_FREQ(CF0), .REFRESH_RATE(RR0), .PULSE_CYCLES(P0)) dut_a (
    .clock(clock), .reset(rst[0]), .refreshRate(out[0]));
  refresh_rate #(.CLOCK_FREQ(CF1), .REFRESH_RATE(RR1), .PULSE_CYCLES(P1)) dut_b (
    .clock(clock), .reset(rst[1]), .refreshRate(out[1]));
  refresh_rate #(.CLOCK_FREQ(CF2), .REFRESH_RATE(RR2), .PULSE_CYCLES(P2)) dut_c (
    .clock(clock), .reset(rst[2]), .refreshRate(out[2]));
  refresh_rate #(.CLOCK_FREQ(CF3), .REFRESH_RATE(RR3), .PULSE_CYCLES(P3)) dut_d (
    .clock(clock), .reset(rst[3]), .refreshRate(out[3]));

  longint cf_t [4] = '{CF0, CF1, CF2, CF3};
  longint rr_t [4] = '{RR0, RR1, RR2, RR3};
  longint p_t  [4] = '{P0, P1, P2, P3};

  int     tests = 0;
  int     fails = 0;
  longint e    [4];
  logic   prev [4];
  int     hold [4];
  longint rises_a [$];
  longint rises_b [$];
  longint rises_d [$];

  longint exp_a [8] = '{14, 28, 42, 57, 71, 85, 100, 114};
  longint exp_b [4] = '{10, 20, 30, 40};
  longint exp_d [3] = '{833, 1666, 2500};
  longint exp_r [4] = '{14, 28, 42, 57};

  // Pulse k rises after edge S_k = floor(k*CF/RR) and stays high for P edges.
  // The latest k with S_k <= e satisfies k*CF < (e+1)*RR.
  function automatic logic model_out(longint cf, longint rr, longint p, longint edge_n);
    longint k, s;
    if (edge_n <= 0) return 1'b0;
    k = ((edge_n + 1) * rr - 1) / cf;
    if (k < 1) return 1'b0;
    s = (k * cf) / rr;
    return (edge_n < s + p);
  endfunction

  task automatic check(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input longint obs, input longint expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: let the DUTs update, then compare every output at the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      logic expv;
      if (rst[i]) begin
        e[i] = 0;
        expv = 1'b0;
      end else begin
        e[i]++;
        expv = model_out(cf_t[i], rr_t[i], p_t[i], e[i]);
      end
      check($sformatf("dut%0d_edge%0d", i, e[i]), out[i], expv);
      if (!rst[i] && out[i] === 1'b1 && prev[i] !== 1'b1) begin
        case (i)
          0: rises_a.push_back(e[i]);
          1: rises_b.push_back(e[i]);
          3: rises_d.push_back(e[i]);
          default: ;
        endcase
      end
      prev[i] = out[i];
    end
  endtask

  initial begin
    int n_le_100;
    for (int i = 0; i < 4; i++) begin
      rst[i]  = 1'b1;
      e[i]    = 0;
      prev[i] = 1'b0;
      hold[i] = 0;
    end

    // Reset held two cycles, then free-run and compare the pulse edges.
    step();
    step();
    for (int i = 0; i < 4; i++) check($sformatf("reset_out%0d", i), out[i], 1'b0);
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    repeat (2600) step();

    check_int("a_rise_count", longint'(rises_a.size()) >= 8, 1);
    for (int j = 0; j < 8; j++)
      if (j < rises_a.size()) check_int($sformatf("a_rise%0d", j), rises_a[j], exp_a[j]);
    n_le_100 = 0;
    foreach (rises_a[j]) if (rises_a[j] <= 100) n_le_100++;
    check_int("a_pulses_in_100", n_le_100, 7);
    check_int("b_rise_count", longint'(rises_b.size()) >= 4, 1);
    for (int j = 0; j < 4; j++)
      if (j < rises_b.size()) check_int($sformatf("b_rise%0d", j), rises_b[j], exp_b[j]);
    check_int("d_rise_count", rises_d.size(), 3);
    for (int j = 0; j < 3; j++)
      if (j < rises_d.size()) check_int($sformatf("d_rise%0d", j), rises_d[j], exp_d[j]);

    // Reset dut_a mid period 2 (edge 20): the pattern restarts from period 1.
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    repeat (19) step();
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    check("a_mid_reset_low", out[0], 1'b0);
    rises_a.delete();
    repeat (60) step();
    check_int("a_restart_count", rises_a.size(), 4);
    for (int j = 0; j < 4; j++)
      if (j < rises_a.size()) check_int($sformatf("a_restart_rise%0d", j), rises_a[j], exp_r[j]);

    // Reset dut_b during the second cycle of its pulse.
    rst[1] = 1'b1; step(); rst[1] = 1'b0;
    repeat (10) step();
    check("b_pulse_cycle1", out[1], 1'b1);
    rst[1] = 1'b1; step(); rst[1] = 1'b0;
    check("b_pulse_cut", out[1], 1'b0);
    repeat (9) step();
    check("b_quiet_before_restart", out[1], 1'b0);
    step();
    check("b_restart_rise", out[1], 1'b1);
    step(); step();
    check("b_restart_cycle3", out[1], 1'b1);
    step();
    check("b_restart_fall", out[1], 1'b0);

    // Random short resets on every instance, checked by the model each cycle.
    for (int c = 0; c < 8000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] > 0) begin
          rst[i] = 1'b1;
          hold[i]--;
        end else if ($urandom_range(1499) == 0) begin
          rst[i]  = 1'b1;
          hold[i] = int'($urandom_range(2));
        end else begin
          rst[i] = 1'b0;
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
